// File: rtl/lock_reset_seq.sv
// rtl/lock_reset_seq.sv - lock-qualified domain reset sequencer and oversample tick generator
// Optional loss statistics are built only when LOCK_LOSS_STATS_EN is defined.
module lock_reset_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 1024,
    parameter int TICK_DIV    = 48
) (
    input  logic       CLK288MHZ,
    input  logic       reset,
    input  logic       stable,
    input  logic       lossClr,
    output logic       rstOut,
    output logic       ready,
    output logic       sampleTick,
    output logic       lockLost,
    output logic [7:0] lockLossCount
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic              stableS;
    logic [HW-1:0]     hold_cnt, hold_next;
    logic [TW-1:0]     tick_cnt, tick_next;
    logic              loss_event;

    always_ff @(posedge CLK288MHZ or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], stable};
        end
    end

    assign stableS = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        tick_next  = '0;
        loss_event = 1'b0;
        case (state)
            WAIT: begin
                hold_next = '0;
                if (stableS) state_next = HOLD;
            end
            HOLD: begin
                if (!stableS) begin
                    state_next = WAIT;
                    hold_next  = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_next = RUN;
                    hold_next  = '0;
                end else begin
                    hold_next = hold_cnt + HW'(1);
                end
            end
            RUN: begin
                if (!stableS) begin
                    state_next = WAIT;
                    loss_event = 1'b1;
                end else begin
                    tick_next = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
                end
            end
            default: state_next = WAIT;
        endcase
    end

    // rstOut and sampleTick are registered from next-state so they are glitch-free flop outputs
    always_ff @(posedge CLK288MHZ or posedge reset) begin
        if (reset) begin
            state      <= WAIT;
            hold_cnt   <= '0;
            tick_cnt   <= '0;
            rstOut     <= 1'b1;
            sampleTick <= 1'b0;
        end else begin
            state      <= state_next;
            hold_cnt   <= hold_next;
            tick_cnt   <= tick_next;
            rstOut     <= (state_next != RUN);
            sampleTick <= (state_next == RUN) && (tick_next == TICK_LAST);
        end
    end

    assign ready = ~rstOut;

`ifdef LOCK_LOSS_STATS_EN
    // A loss coinciding with a clear wins: the count restarts at 1
    always_ff @(posedge CLK288MHZ or posedge reset) begin
        if (reset) begin
            lockLost      <= 1'b0;
            lockLossCount <= '0;
        end else if (loss_event) begin
            lockLost <= 1'b1;
            if (lossClr) begin
                lockLossCount <= 8'd1;
            end else if (lockLossCount != 8'hFF) begin
                lockLossCount <= lockLossCount + 8'd1;
            end
        end else if (lossClr) begin
            lockLost      <= 1'b0;
            lockLossCount <= '0;
        end
    end
`else
    logic unused_stats;
    assign unused_stats  = lossClr ^ loss_event;
    assign lockLost      = 1'b0;
    assign lockLossCount = '0;
`endif

endmodule

// File: tb/tb_lock_reset_seq.sv
// tb/tb_lock_reset_seq.sv - directed self-checking bench for lock_reset_seq
module tb_lock_reset_seq;

`ifdef LOCK_LOSS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       stable_a = 1'b1;
    logic       stable_b = 1'b0;
    logic       clr_a = 1'b0;
    logic       clr_b = 1'b0;
    logic       rst_a, ready_a, tick_a, lost_a;
    logic [7:0] cnt_a;
    logic       rst_b, ready_b, tick_b, lost_b;
    logic [7:0] cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lock_reset_seq dut (
        .CLK288MHZ(clk), .reset(reset), .stable(stable_a), .lossClr(clr_a),
        .rstOut(rst_a), .ready(ready_a), .sampleTick(tick_a),
        .lockLost(lost_a), .lockLossCount(cnt_a)
    );

    lock_reset_seq #(.SYNC_STAGES(2), .HOLD_CYCLES(4), .TICK_DIV(48)) dut4 (
        .CLK288MHZ(clk), .reset(reset), .stable(stable_b), .lossClr(clr_b),
        .rstOut(rst_b), .ready(ready_b), .sampleTick(tick_b),
        .lockLost(lost_b), .lockLossCount(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Release from a fresh edge 0: rstOut high after edge 1025, low after 1026, first tick after 1073
    task automatic release_seq(input string tag);
        cyc(1026);
        check({tag, "_rst_pre"}, 32'(rst_a), 1);
        cyc(1);
        check({tag, "_rst_rel"}, 32'(rst_a), 0);
        check({tag, "_ready_rel"}, 32'(ready_a), 1);
        for (int e = 1027; e <= 1073; e++) begin
            cyc(1);
            check({tag, "_tick"}, 32'(tick_a), (e == 1073) ? 1 : 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        cyc(5);
        check("reset_rstOut", 32'(rst_a), 1);
        check("reset_ready", 32'(ready_a), 0);
        check("reset_tick", 32'(tick_a), 0);
        check("reset_lost", 32'(lost_a), 0);
        check("reset_count", 32'(cnt_a), 0);
        reset = 1'b0;

        // default release latency and tick spacing
        cyc(1026);
        check("rel_rst_1025", 32'(rst_a), 1);
        check("rel_ready_1025", 32'(ready_a), 0);
        cyc(1);
        check("rel_rst_1026", 32'(rst_a), 0);
        check("rel_ready_1026", 32'(ready_a), 1);
        for (int e = 1027; e <= 1125; e++) begin
            cyc(1);
            check("tick_spacing", 32'(tick_a), (((e - 1026) % 48) == 47) ? 1 : 0);
        end

        // lock loss in RUN: stable falls before edge k=1126
        stable_a = 1'b0;
        cyc(2);
        check("loss_rst_k1", 32'(rst_a), 0);
        check("loss_ready_k1", 32'(ready_a), 1);
        cyc(1);
        check("loss_rst_k2", 32'(rst_a), 1);
        check("loss_ready_k2", 32'(ready_a), 0);
        check("loss_tick_k2", 32'(tick_a), 0);
        check("loss_lost", 32'(lost_a), STATS ? 1 : 0);
        check("loss_count", 32'(cnt_a), STATS ? 1 : 0);
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            check("loss_no_tick", 32'(tick_a), 0);
            check("loss_rst_held", 32'(rst_a), 1);
        end

        // re-lock repeats the full release sequence
        stable_a = 1'b1;
        release_seq("relock");
        check("relock_count", 32'(cnt_a), STATS ? 1 : 0);

        // async reset mid-RUN, between ticks
        cyc(10);
        reset = 1'b1;
        #1;
        check("async_rst", 32'(rst_a), 1);
        check("async_ready", 32'(ready_a), 0);
        check("async_tick", 32'(tick_a), 0);
        check("async_lost", 32'(lost_a), 0);
        check("async_count", 32'(cnt_a), 0);
        #2;
        reset = 1'b0;
        release_seq("post_reset");
        check("post_reset_count", 32'(cnt_a), 0);
        check("post_reset_lost", 32'(lost_a), 0);

        // single-cycle drop at hold count 500 restarts the full interval
        reset = 1'b1;
        #1;
        reset = 1'b0;
        cyc(503);
        check("hold_rst_500", 32'(rst_a), 1);
        stable_a = 1'b0;
        cyc(1);
        stable_a = 1'b1;
        cyc(1026);
        check("hold_rst_1529", 32'(rst_a), 1);
        cyc(1);
        check("hold_rst_1530", 32'(rst_a), 0);
        check("hold_ready_1530", 32'(ready_a), 1);
        check("hold_count", 32'(cnt_a), 0);
        check("hold_lost", 32'(lost_a), 0);

        // saturation with HOLD_CYCLES=4
        for (int i = 0; i < 256; i++) begin
            stable_b = 1'b1;
            cyc(6);
            check("sat_rst_pre", 32'(rst_b), 1);
            cyc(1);
            check("sat_ready", 32'(ready_b), 1);
            stable_b = 1'b0;
            cyc(3);
            check("sat_rst_loss", 32'(rst_b), 1);
            check("sat_count", 32'(cnt_b), STATS ? ((i + 1 > 255) ? 255 : i + 1) : 0);
        end
        check("sat_lost", 32'(lost_b), STATS ? 1 : 0);

        // lossClr coinciding with a loss event
        stable_b = 1'b1;
        cyc(7);
        check("coinc_ready", 32'(ready_b), 1);
        stable_b = 1'b0;
        cyc(2);
        clr_b = 1'b1;
        cyc(1);
        clr_b = 1'b0;
        check("coinc_count", 32'(cnt_b), STATS ? 1 : 0);
        check("coinc_lost", 32'(lost_b), STATS ? 1 : 0);

        // lossClr alone clears the statistics
        cyc(2);
        clr_b = 1'b1;
        cyc(1);
        clr_b = 1'b0;
        check("clr_count", 32'(cnt_b), 0);
        check("clr_lost", 32'(lost_b), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_reset_seq.md
# lock_reset_seq

Lock-qualified reset sequencer and oversample tick generator for the 288 MHz UART domain. Sits directly downstream of the MMCM frequency synthesizer and consumes its 288 MHz output clock and asynchronous `stable` (lock) flag. Releases a synchronous-deassert domain reset only after lock has held continuously for a programmable interval, then emits the sampling tick that paces the 6 Mbaud UART datapath. Loss of lock at any time re-asserts the domain reset.

## Interface
- SYNC_STAGES, 2: synchronizer depth for `stable`; minimum 2.
- HOLD_CYCLES, 1024: consecutive synchronized-lock cycles required before release; minimum 1.
- TICK_DIV, 48: `CLK288MHZ` cycles per `sampleTick` (288 MHz / 6 MHz); minimum 2.

- CLK288MHZ  in  1  domain clock from the synthesizer BUFG.
- reset  in  1  asynchronous, active-high; clears all state.
- stable  in  1  MMCM lock flag; asynchronous to `CLK288MHZ`.
- lossClr  in  1  single-cycle pulse; clears loss statistics.
- rstOut  out  1  domain reset for downstream logic; active-high, deasserts synchronously.
- ready  out  1  high exactly while in RUN; equals `~rstOut`.
- sampleTick  out  1  one-cycle pulse every TICK_DIV cycles in RUN.
- lockLost  out  1  sticky; set on any lock loss while in RUN.
- lockLossCount  out  8  count of lock losses while in RUN; saturates at 255.

## Operation
- `stable` passes through SYNC_STAGES flops, reset value 0; the last stage is `stableS`. The FSM and all other logic use only `stableS`.
- FSM states:
  - WAIT: `rstOut`=1, hold counter=0. Goes to HOLD when `stableS`=1.
  - HOLD: `rstOut`=1; counter increments each cycle `stableS`=1. If `stableS`=0, return to WAIT and clear the counter. When the counter reaches HOLD_CYCLES-1 with `stableS`=1, go to RUN.
  - RUN: `rstOut`=0, `ready`=1. If `stableS`=0, go to WAIT.
- Tick counter: width clog2(TICK_DIV). Held at 0 outside RUN. In RUN it counts 0..TICK_DIV-1 and wraps. `sampleTick` is registered and asserts on the cycle the counter equals TICK_DIV-1.
- Loss event: a RUN to WAIT transition. It sets `lockLost` and increments `lockLossCount`; the count holds at 255 once reached. Losses during WAIT or HOLD are not counted.
- `lossClr` clears `lockLost` and `lockLossCount`. If it coincides with a loss event, the loss wins: `lockLost`=1, `lockLossCount`=1.
- Reset values: state WAIT, `rstOut`=1, `ready`=0, `sampleTick`=0, `lockLost`=0, `lockLossCount`=0, all counters and sync flops 0.
- Asserting `reset` mid-RUN forces these values immediately and asynchronously. It is not counted as a loss event.

## Timing
- `rstOut` assertion is asynchronous only via `reset`. Deassertion always occurs on a `CLK288MHZ` edge.
- Release latency: `stable` high and meeting setup before edge 0, with no drops, gives `stableS`=1 after edge SYNC_STAGES-1. `rstOut` falls after edge SYNC_STAGES+HOLD_CYCLES. With defaults, that is edge 1026.
- First `sampleTick` is high for the cycle following edge SYNC_STAGES+HOLD_CYCLES+TICK_DIV-1. After that it pulses every TICK_DIV cycles, each pulse exactly one cycle wide.
- Lock-loss response: `stable` falls before edge k. `stableS`=0 after edge k+SYNC_STAGES-1. On edge k+SYNC_STAGES:
  - `rstOut`=1 and `ready`=0;
  - `sampleTick` is forced to 0;
  - the tick counter is cleared;
  - `lockLost` and `lockLossCount` update.
- A `stableS` drop of a single cycle during HOLD restarts the full HOLD_CYCLES interval.

## Configuration
- LOCK_LOSS_STATS_EN defined: `lockLost`, `lockLossCount`, and `lossClr` handling are implemented as described above.
- Not defined: `lockLost` and `lockLossCount` are tied to 0 and `lossClr` is ignored. FSM, reset and tick behaviour are unchanged.

## Test plan
- Default parameters; `reset` high for 5 cycles, then low; `stable`=1 constant from time 0 -> `rstOut` falls after edge 1026 following reset release; first `sampleTick` 48 cycles later; pulses then spaced exactly 48 cycles.
- `stable` drops for 1 cycle at hold count 500 -> FSM returns to WAIT; `rstOut` stays high for a further full 1024 synchronized cycles; `lockLossCount` stays 0.
- In RUN, `stable` falls -> 2 edges later `rstOut`=1, `ready`=0, no further `sampleTick`; `lockLost`=1, `lockLossCount`=1; re-lock runs the full release sequence again.
- 256 lock-loss cycles with HOLD_CYCLES=4 -> `lockLossCount` saturates at 255. `lossClr` coinciding with a loss event -> `lockLossCount`=1, `lockLost`=1.
- `reset` pulsed mid-RUN between ticks -> `rstOut`=1 asynchronously; tick counter cleared; statistics cleared to 0; no loss counted.
- Build with LOCK_LOSS_STATS_EN undefined and repeat the loss scenario -> `lockLost`=0, `lockLossCount`=0; reset and tick timing identical to the first scenario.
